// File: rtl/tb_stream_loader_if.sv
// Word stream carrying headers, payload and (optionally) checksum words into
// the loader.
//   S_VALID  producer has a word on S_DATA
//   S_READY  loader accepts the word this cycle
//   S_DATA   32-bit stream word
interface tb_stream_loader_if;
    logic        S_VALID;
    logic        S_READY;
    logic [31:0] S_DATA;

    modport master (output S_VALID, output S_DATA, input S_READY);
    modport slave  (input S_VALID, input S_DATA, output S_READY);
endinterface

// File: rtl/tb_stream_loader.sv
// Load master for the core's program/data memory load ports. Consumes a
// header + payload segment stream and turns each payload word into a one-cycle
// write strobe on the program or data load port. After the last segment it
// waits START_DELAY idle cycles and raises a sticky START.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, each segment's payload is followed by one word holding the
//   32-bit wrapping sum of that payload. A mismatch drives the loader into ERR.
//
// Ports
//   CLK, RSTn             clock (rising edge), async active-low reset
//   s_if (slave)          S_VALID / S_READY / S_DATA word stream
//   TB_LOAD_PROGRAM_*     program-memory strobe, word address, write data
//   TB_LOAD_DATA_*        data-memory strobe, word address, write data
//   START                 sticky core start once loading completes
//   BUSY                  high while loading payload, checking, or waiting
//   ERR                   sticky protocol/checksum error
module tb_stream_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned START_DELAY = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    tb_stream_loader_if.slave s_if,
    output logic              TB_LOAD_PROGRAM_CTRL,
    output logic [ADDR_W-1:0] TB_LOAD_PROGRAM_ADDR,
    output logic [31:0]       TB_LOAD_PROGRAM_DATA,
    output logic              TB_LOAD_DATA_CTRL,
    output logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR,
    output logic [31:0]       TB_LOAD_DATA_DATA,
    output logic              START,
    output logic              BUSY,
    output logic              ERR
);
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned WAIT_W = 4;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_CHK, ST_WAIT, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_WAIT, ST_RUN, ST_ERR} state_t;
`endif

    state_t              r_state;
    state_t              state_next;

    logic                r_ready;
    logic                r_busy;
    logic                r_start;
    logic                r_err;

    logic                r_target;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [WAIT_W-1:0]   r_wait;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    logic                r_prog_ctrl;
    logic [ADDR_W-1:0]   r_prog_addr;
    logic [31:0]         r_prog_data;
    logic                r_data_ctrl;
    logic [ADDR_W-1:0]   r_data_addr;
    logic [31:0]         r_data_data;

    logic                w_beat;
    logic                w_hdr_ok;
    logic                w_ready_next;
    logic                w_busy_next;

    assign w_beat   = s_if.S_VALID & r_ready;
    assign w_hdr_ok = (s_if.S_DATA[19:10] != CNT_W'(0)) && (s_if.S_DATA[9:0] == 10'd0);

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= ST_HDR;
        else       r_state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = r_state;
        case (r_state)
            ST_HDR:  if (w_beat) state_next = w_hdr_ok ? ST_LOAD : ST_ERR;
            ST_LOAD: if (w_beat && (r_cnt == CNT_W'(1))) begin
`ifdef LOADER_CHECKSUM_EN
                         state_next = ST_CHK;
`else
                         state_next = r_last ? ST_WAIT : ST_HDR;
`endif
                     end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:  if (w_beat) begin
                         if (s_if.S_DATA != r_sum) state_next = ST_ERR;
                         else                      state_next = r_last ? ST_WAIT : ST_HDR;
                     end
`endif
            // WAIT spans START_DELAY+1 cycles, so START lands START_DELAY idle
            // cycles after the last strobe (one cycle when START_DELAY is 0).
            ST_WAIT: if (r_wait == WAIT_W'(START_DELAY)) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_HDR;
        endcase
    end

    // Status outputs are registered decodes of the state being entered
`ifdef LOADER_CHECKSUM_EN
    assign w_ready_next = (state_next == ST_HDR) || (state_next == ST_LOAD) || (state_next == ST_CHK);
    assign w_busy_next  = (state_next == ST_LOAD) || (state_next == ST_CHK) || (state_next == ST_WAIT);
`else
    assign w_ready_next = (state_next == ST_HDR) || (state_next == ST_LOAD);
    assign w_busy_next  = (state_next == ST_LOAD) || (state_next == ST_WAIT);
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
            r_start <= (state_next == ST_RUN);
            r_err   <= (state_next == ST_ERR);
        end
    end

    // Segment bookkeeping and memory write strobes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_target    <= 1'b0;
            r_last      <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wait      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
            r_prog_ctrl <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_data_ctrl <= 1'b0;
            r_data_addr <= '0;
            r_data_data <= '0;
        end else begin
            r_prog_ctrl <= 1'b0;
            r_data_ctrl <= 1'b0;
            r_wait      <= (r_state == ST_WAIT) ? (r_wait + WAIT_W'(1)) : '0;

            if ((r_state == ST_HDR) && w_beat && w_hdr_ok) begin
                r_target <= s_if.S_DATA[31];
                r_last   <= s_if.S_DATA[30];
                r_addr   <= ADDR_W'(s_if.S_DATA[29:20]);
                r_cnt    <= s_if.S_DATA[19:10];
`ifdef LOADER_CHECKSUM_EN
                r_sum    <= '0;
`endif
            end

            if ((r_state == ST_LOAD) && w_beat) begin
                if (r_target) begin
                    r_data_ctrl <= 1'b1;
                    r_data_addr <= r_addr;
                    r_data_data <= s_if.S_DATA;
                end else begin
                    r_prog_ctrl <= 1'b1;
                    r_prog_addr <= r_addr;
                    r_prog_data <= s_if.S_DATA;
                end
                // Address wraps silently at 2^ADDR_W
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                r_sum  <= r_sum + s_if.S_DATA;
`endif
            end
        end
    end

    assign s_if.S_READY         = r_ready;
    assign TB_LOAD_PROGRAM_CTRL = r_prog_ctrl;
    assign TB_LOAD_PROGRAM_ADDR = r_prog_addr;
    assign TB_LOAD_PROGRAM_DATA = r_prog_data;
    assign TB_LOAD_DATA_CTRL    = r_data_ctrl;
    assign TB_LOAD_DATA_ADDR    = r_data_addr;
    assign TB_LOAD_DATA_DATA    = r_data_data;
    assign START                = r_start;
    assign BUSY                 = r_busy;
    assign ERR                  = r_err;
endmodule

// File: tb/tb_tb_stream_loader.sv
// Self-checking bench for tb_stream_loader: random segment streams are driven
// through the stream interface; a reference model derives the expected memory
// write sequence, strobe cycles and START timing from the segment contents.
module tb_tb_stream_loader;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned START_DELAY = 2;

    logic              CLK  = 1'b0;
    logic              RSTn = 1'b0;
    logic              TB_LOAD_PROGRAM_CTRL;
    logic [ADDR_W-1:0] TB_LOAD_PROGRAM_ADDR;
    logic [31:0]       TB_LOAD_PROGRAM_DATA;
    logic              TB_LOAD_DATA_CTRL;
    logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR;
    logic [31:0]       TB_LOAD_DATA_DATA;
    logic              START;
    logic              BUSY;
    logic              ERR;

    tb_stream_loader_if s_if ();

    tb_stream_loader #(.ADDR_W(ADDR_W), .START_DELAY(START_DELAY)) dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .s_if                 (s_if),
        .TB_LOAD_PROGRAM_CTRL (TB_LOAD_PROGRAM_CTRL),
        .TB_LOAD_PROGRAM_ADDR (TB_LOAD_PROGRAM_ADDR),
        .TB_LOAD_PROGRAM_DATA (TB_LOAD_PROGRAM_DATA),
        .TB_LOAD_DATA_CTRL    (TB_LOAD_DATA_CTRL),
        .TB_LOAD_DATA_ADDR    (TB_LOAD_DATA_ADDR),
        .TB_LOAD_DATA_DATA    (TB_LOAD_DATA_DATA),
        .START                (START),
        .BUSY                 (BUSY),
        .ERR                  (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         obs_q[$];
    int          obs_cyc_q[$];
    wr_t         exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] seg_words[$];

    int   cyc        = 0;
    int   start_cyc  = -1;
    logic prev_start = 1'b0;
    int   last_beat  = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Records every strobe with its cycle and the cycle START first rises
    always @(negedge CLK) begin
        if (!RSTn) begin
            start_cyc  <= -1;
            prev_start <= 1'b0;
        end else begin
            if (TB_LOAD_PROGRAM_CTRL) begin
                obs_q.push_back(wr_t'{port: 1'b0, addr: TB_LOAD_PROGRAM_ADDR, data: TB_LOAD_PROGRAM_DATA});
                obs_cyc_q.push_back(cyc);
            end
            if (TB_LOAD_DATA_CTRL) begin
                obs_q.push_back(wr_t'{port: 1'b1, addr: TB_LOAD_DATA_ADDR, data: TB_LOAD_DATA_DATA});
                obs_cyc_q.push_back(cyc);
            end
            if (START && !prev_start) start_cyc <= cyc;
            prev_start <= START;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        s_if.S_VALID = 1'b0;
        repeat (n) begin
            s_if.S_DATA = $urandom;
            @(posedge CLK);
            #1;
        end
    endtask

    // Offers one word until accepted; last_beat receives the beat cycle
    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        s_if.S_VALID = 1'b1;
        s_if.S_DATA  = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (s_if.S_READY) begin
                @(posedge CLK);
                #1;
                last_beat = cyc;
                ok = 1'b1;
                break;
            end
        end
        s_if.S_VALID = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept: word %08h not accepted, S_READY got 0 required 1", w);
        end
    endtask

    // Sends header + seg_words (+ checksum) and appends the model's expected writes
    task automatic send_segment(input logic tgt, input logic lst, input logic [9:0] base, input int gap_max);
        logic [31:0] sum = 32'd0;
        int n = seg_words.size();
        send_word({tgt, lst, base, 10'(n), 10'd0});
        for (int k = 0; k < n; k++) begin
            idle(int'($urandom_range(gap_max, 0)));
            send_word(seg_words[k]);
            exp_q.push_back(wr_t'{port: tgt, addr: ADDR_W'((int'(base) + k) % (1 << ADDR_W)), data: seg_words[k]});
            exp_cyc_q.push_back(last_beat);
            sum = sum + seg_words[k];
        end
`ifdef LOADER_CHECKSUM_EN
        idle(int'($urandom_range(gap_max, 0)));
        send_word(sum);
`endif
    endtask

    task automatic do_reset();
        s_if.S_VALID = 1'b0;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic test_reset();
        s_if.S_VALID = 1'b0;
        s_if.S_DATA  = 32'd0;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({TB_LOAD_PROGRAM_CTRL, TB_LOAD_PROGRAM_ADDR, TB_LOAD_PROGRAM_DATA, TB_LOAD_DATA_CTRL,
             TB_LOAD_DATA_ADDR, TB_LOAD_DATA_DATA, START, BUSY, ERR, s_if.S_READY} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        RSTn = 1'b1;
        #1;
        n_checks++;
        if (s_if.S_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_early: S_READY got %b required 0 before first edge", s_if.S_READY);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (s_if.S_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise: S_READY got %b required 1", s_if.S_READY);
        end
    endtask

    task automatic test_basic();
        int base;
        int seen = 0;
        do_reset();
        base = obs_q.size();
        seg_words = '{$urandom, $urandom, $urandom};
        send_segment(1'b0, 1'b1, 10'd0, 0);
        @(negedge CLK);
        n_checks++;
`ifdef LOADER_CHECKSUM_EN
        if (BUSY !== 1'b1 || START !== 1'b0) begin
`else
        if (BUSY !== 1'b1 || START !== 1'b0 || TB_LOAD_PROGRAM_CTRL !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL basic_wait: BUSY=%b START=%b required BUSY=1 START=0", BUSY, START);
        end
        for (int i = 0; i < 40 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (start_cyc !== last_beat + int'(START_DELAY) + 1) begin
            n_fail++;
            $display("FAIL basic_start_time: START rose at cycle %0d required %0d", start_cyc, last_beat + int'(START_DELAY) + 1);
        end
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: %0d strobes required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== exp_cyc_q[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h@%0d required %h@%0d", i, obs_q[base+i], obs_cyc_q[base+i], exp_q[i], exp_cyc_q[i]);
            end
        end
        // RUN ignores further words
        base = obs_q.size();
        s_if.S_VALID = 1'b1;
        s_if.S_DATA  = 32'h4000_0C00;
        repeat (5) begin
            @(negedge CLK);
            if (s_if.S_READY) seen++;
        end
        s_if.S_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (seen != 0 || obs_q.size() != base || START !== 1'b1 || BUSY !== 1'b0 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL run_hold: ready_cycles=%0d new_strobes=%0d START=%b BUSY=%b ERR=%b required 0 0 1 0 0",
                     seen, obs_q.size() - base, START, BUSY, ERR);
        end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = obs_q.size();
        seg_words = '{$urandom, $urandom, $urandom, $urandom};
        send_segment(1'b1, 1'b1, 10'h3FE, 0);
        for (int i = 0; i < 40 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: %0d strobes required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== exp_cyc_q[i]) begin
                n_fail++;
                $display("FAIL wrap_write%0d: got %h@%0d required %h@%0d", i, obs_q[base+i], obs_cyc_q[base+i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_checks++;
        if (START !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_start: START got %b required 1", START);
        end
    endtask

    task automatic test_stall();
        int base;
        do_reset();
        base = obs_q.size();
        seg_words.delete();
        repeat (6) seg_words.push_back($urandom);
        send_segment(1'b0, 1'b1, 10'(($urandom_range(1023, 0))), 3);
        for (int i = 0; i < 40 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: %0d strobes required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== exp_cyc_q[i]) begin
                n_fail++;
                $display("FAIL stall_write%0d: got %h@%0d required %h@%0d", i, obs_q[base+i], obs_cyc_q[base+i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_checks++;
        if (start_cyc !== last_beat + int'(START_DELAY) + 1) begin
            n_fail++;
            $display("FAIL stall_start_time: START rose at cycle %0d required %0d", start_cyc, last_beat + int'(START_DELAY) + 1);
        end
    endtask

    // Several segments, repeated targets and overlapping ranges
    task automatic test_multi_segment();
        int base;
        int nseg = 4;
        do_reset();
        base = obs_q.size();
        for (int s = 0; s < nseg; s++) begin
            logic tgt = (s < 2) ? 1'b0 : 1'($urandom_range(1, 0));
            logic [9:0] b = (s < 2) ? 10'(5 + s) : 10'($urandom_range(1023, 0));
            seg_words.delete();
            repeat (int'($urandom_range(6, 1))) seg_words.push_back($urandom);
            send_segment(tgt, (s == nseg - 1), b, 2);
        end
        for (int i = 0; i < 60 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL multi_count: %0d strobes required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_cyc_q[base+i] !== exp_cyc_q[i]) begin
                n_fail++;
                $display("FAIL multi_write%0d: got %h@%0d required %h@%0d", i, obs_q[base+i], obs_cyc_q[base+i], exp_q[i], exp_cyc_q[i]);
            end
        end
        n_checks++;
        if (start_cyc !== last_beat + int'(START_DELAY) + 1 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_start_time: START rose at cycle %0d ERR=%b required %0d ERR=0", start_cyc, ERR, last_beat + int'(START_DELAY) + 1);
        end
    endtask

    task automatic test_hdr_error(input logic [31:0] hdr);
        int base;
        int seen = 0;
        do_reset();
        base = obs_q.size();
        send_word(hdr);
        @(negedge CLK);
        n_checks++;
        if (ERR !== 1'b1 || s_if.S_READY !== 1'b0 || START !== 1'b0) begin
            n_fail++;
            $display("FAIL hdr_err_%08h: ERR=%b S_READY=%b START=%b required 1 0 0", hdr, ERR, s_if.S_READY, START);
        end
        s_if.S_VALID = 1'b1;
        s_if.S_DATA  = 32'h4000_0C00;
        repeat (10) begin
            @(negedge CLK);
            if (s_if.S_READY) seen++;
        end
        s_if.S_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (seen != 0 || obs_q.size() != base || START !== 1'b0 || ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL hdr_err_sticky_%08h: ready_cycles=%0d strobes=%0d START=%b ERR=%b required 0 0 0 1",
                     hdr, seen, obs_q.size() - base, START, ERR);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        send_word({1'b1, 1'b1, 10'd40, 10'd5, 10'd0});
        send_word($urandom);
        send_word($urandom);
        #2;
        RSTn = 1'b0;
        #1;
        n_checks++;
        if ({TB_LOAD_PROGRAM_CTRL, TB_LOAD_PROGRAM_ADDR, TB_LOAD_PROGRAM_DATA, TB_LOAD_DATA_CTRL,
             TB_LOAD_DATA_ADDR, TB_LOAD_DATA_DATA, START, BUSY, ERR, s_if.S_READY} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: outputs nonzero right after RSTn fell, required all 0");
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        base = obs_q.size();
        seg_words.delete();
        repeat (5) seg_words.push_back($urandom);
        send_segment(1'b1, 1'b1, 10'd40, 1);
        for (int i = 0; i < 40 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid_count: %0d strobes required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL reset_mid_write%0d: got %h required %h", i, obs_q[base+i], exp_q[i]);
            end
        end
        n_checks++;
        if (START !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_start: START got %b required 1", START);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        do_reset();
        seg_words = '{32'd1, 32'd2, 32'd3};
        send_segment(1'b1, 1'b1, 10'd8, 0);
        for (int i = 0; i < 40 && start_cyc < 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (START !== 1'b1 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_good: START=%b ERR=%b required 1 0", START, ERR);
        end
        do_reset();
        base = obs_q.size();
        send_word({1'b0, 1'b1, 10'd8, 10'd3, 10'd0});
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd3);
        send_word(32'd7);
        repeat (8) @(negedge CLK);
        n_checks++;
        if (START !== 1'b0 || ERR !== 1'b1 || obs_q.size() - base != 3) begin
            n_fail++;
            $display("FAIL chk_bad: START=%b ERR=%b strobes=%0d required 0 1 3", START, ERR, obs_q.size() - base);
        end
    endtask
`endif

    initial begin
        s_if.S_VALID = 1'b0;
        s_if.S_DATA  = 32'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_multi_segment();
        test_hdr_error(32'h4000_0000);
        test_hdr_error(32'h4000_0C01);
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
